// File: rtl/anfsqrt_sqrt_seq.sv
// Sequential restoring square root: one root bit per BUSY cycle, MSB first.
// Optional round-to-nearest of the root is enabled with macro ANFSQRT_ROUND_EN.
module anfsqrt_sqrt_seq #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   query,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH/2-1:0] result,
    output logic [WIDTH/2:0]   rem,
    output logic               busy
);

    localparam int HALF = WIDTH / 2;
    localparam int CW   = $clog2(HALF + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  rad_q, rad_d;
    logic [HALF-1:0]   root_q, root_d;
    logic [HALF+1:0]   rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [HALF-1:0]   result_q, result_d;
    logic [HALF:0]     rem_out_q, rem_out_d;

    logic [HALF+1:0]   rem_sh;
    logic [HALF+2:0]   trial;
    logic              trial_neg;
    logic [HALF+1:0]   step_rem;
    logic [HALF-1:0]   step_root;
    logic [HALF-1:0]   fin_root;

    // Before the last step the partial remainder never exceeds HALF bits,
    // so dropping its top two bits before the shift loses nothing.
    always_comb begin
        rem_sh    = {rem_q[HALF-1:0], rad_q[WIDTH-1 -: 2]};
        trial     = {1'b0, rem_sh} - {1'b0, root_q, 2'b01};
        trial_neg = trial[HALF+2];
        step_rem  = trial_neg ? rem_sh : trial[HALF+1:0];
        step_root = {root_q[HALF-2:0], ~trial_neg};
    end

`ifdef ANFSQRT_ROUND_EN
    always_comb begin
        fin_root = step_root;
        if (step_rem > {2'b00, step_root} && !(&step_root))
            fin_root = step_root + {{(HALF-1){1'b0}}, 1'b1};
    end
`else
    assign fin_root = step_root;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        rad_d     = rad_q;
        root_d    = root_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        rem_out_d = rem_out_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rad_d   = query;
                    root_d  = '0;
                    rem_d   = '0;
                    cnt_d   = CW'(HALF);
                    state_d = BUSY;
                end
            end
            BUSY: begin
                rad_d  = rad_q << 2;
                root_d = step_root;
                rem_d  = step_rem;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d  = fin_root;
                    rem_out_d = step_rem[HALF:0];
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rad_q     <= '0;
            root_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            rem_out_q <= '0;
        end else begin
            state_q   <= state_d;
            rad_q     <= rad_d;
            root_q    <= root_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            rem_out_q <= rem_out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == BUSY);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign rem       = rem_out_q;

endmodule

// File: tb/tb_anfsqrt_sqrt_seq.sv
// Directed bench for anfsqrt_sqrt_seq (WIDTH=32); expected roots are hand-computed,
// with the rounded column selected when ANFSQRT_ROUND_EN is defined.
module tb_anfsqrt_sqrt_seq;

    localparam int WIDTH = 32;
    localparam int HALF  = WIDTH / 2;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  query;
    logic              out_valid;
    logic              out_ready;
    logic [HALF-1:0]   result;
    logic [HALF:0]     rem;
    logic              busy;

    int n_vec;
    int n_err;

    anfsqrt_sqrt_seq #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .query     (query),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .rem       (rem),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vector(input logic [31:0] q, input logic [15:0] exp_root,
                              input logic [16:0] exp_rem, input bit hold);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", in_ready, 1);
        in_valid = 1'b1;
        query    = q;
        tick();
        check("busy_after_accept", busy, 1);
        // Keep in_valid high with a different radicand while busy: both must be ignored.
        query = ~q;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        in_valid = 1'b0;
        // Edges counted including the accepting edge itself.
        check("latency_edges", lat + 1, HALF + 1);
        check("result", result, exp_root);
        check("rem", rem, exp_rem);
        if (hold) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            query     = 32'd5;
            for (int i = 0; i < 10; i++) begin
                tick();
                check("hold_out_valid", out_valid, 1);
                check("hold_in_ready", in_ready, 0);
                check("hold_result", result, exp_root);
                check("hold_rem", rem, exp_rem);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        tick();
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_in_ready", in_ready, 1);
    endtask

    typedef struct {
        logic [31:0] q;
        logic [15:0] floor_root;
        logic [15:0] round_root;
        logic [16:0] rem;
        bit          hold;
    } vec_t;

    vec_t vecs[12];

    initial begin
        bit seen_valid;
        n_vec = 0;
        n_err = 0;
        vecs[0]  = '{32'd16,         16'd4,     16'd4,     17'd0,      1'b0};
        vecs[1]  = '{32'd15,         16'd3,     16'd4,     17'd6,      1'b0};
        vecs[2]  = '{32'd0,          16'd0,     16'd0,     17'd0,      1'b0};
        vecs[3]  = '{32'hFFFF_FFFF,  16'd65535, 16'd65535, 17'd131070, 1'b0};
        vecs[4]  = '{32'd1,          16'd1,     16'd1,     17'd0,      1'b0};
        vecs[5]  = '{32'd2,          16'd1,     16'd1,     17'd1,      1'b0};
        vecs[6]  = '{32'd3,          16'd1,     16'd2,     17'd2,      1'b0};
        vecs[7]  = '{32'd99,         16'd9,     16'd10,    17'd18,     1'b1};
        vecs[8]  = '{32'd1000000,    16'd1000,  16'd1000,  17'd0,      1'b0};
        vecs[9]  = '{32'h4000_0000,  16'd32768, 16'd32768, 17'd0,      1'b0};
        vecs[10] = '{32'hFFFE_0001,  16'd65535, 16'd65535, 17'd0,      1'b0};
        vecs[11] = '{32'hFFFE_0000,  16'd65534, 16'd65535, 17'd131068, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        query     = '0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_result", result, 0);
        check("rst_rem", rem, 0);

        // Reset wins over a simultaneous accept.
        in_valid = 1'b1;
        query    = 32'd49;
        tick();
        check("rst_prio_busy", busy, 0);
        check("rst_prio_in_ready", in_ready, 1);
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();

        foreach (vecs[i]) begin
`ifdef ANFSQRT_ROUND_EN
            run_vector(vecs[i].q, vecs[i].round_root, vecs[i].rem, vecs[i].hold);
`else
            run_vector(vecs[i].q, vecs[i].floor_root, vecs[i].rem, vecs[i].hold);
`endif
        end

        // Abort in the eighth BUSY cycle; the pending result must never appear.
        in_valid = 1'b1;
        query    = 32'hFFFF_FFFF;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        check("abort_busy_before_rst", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_rem", rem, 0);
        seen_valid = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid) seen_valid = 1'b1;
        end
        check("abort_no_out_valid", seen_valid, 0);
        run_vector(32'd144, 16'd12, 17'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
